// File: rtl/smpl_trigger.sv
// smpl_trigger: decimates a raw ADC stream, arms on request, waits for a
// level crossing with hysteresis on the selected slope, then emits W
// consecutive decimated samples beginning with the triggering one.
// Latency: adc_valid cycle -> smpl_valid two cycles later (input register + output register).
// Backpressure: none; smpl_valid is a write strobe the downstream FIFO must accept.
//
// Optional build macro SMPL_TRIGGER_AUTO_EN adds the timeout counter and
// auto-trigger path; without it auto_mode is ignored and auto_fired is 0.
//
// Ports:
//   clkSmpl, reset       sample clock, asynchronous active-high reset
//   adc_data/adc_valid   raw ADC sample and its qualifier
//   arm                  level request to start a capture from Idle
//   level, slope         trigger level code, 0 = rising / 1 = falling
//   auto_mode            enable forced capture after TIMEOUT kept samples
//   div                  keep one of every div+1 valid samples
//   smpl_data/smpl_valid captured sample and write strobe
//   capturing, done      in-capture flag, one-cycle end-of-capture pulse
//   auto_fired           last capture was forced by the timeout
module smpl_trigger #(
  parameter int W       = 320,
  parameter int HYST    = 8,
  parameter int TIMEOUT = 65536,
  parameter int DIV_W   = 8
) (
  input  logic             clkSmpl,
  input  logic             reset,
  input  logic [9:0]       adc_data,
  input  logic             adc_valid,
  input  logic             arm,
  input  logic [9:0]       level,
  input  logic             slope,
  input  logic             auto_mode,
  input  logic [DIV_W-1:0] div,
  output logic [9:0]       smpl_data,
  output logic             smpl_valid,
  output logic             capturing,
  output logic             done,
  output logic             auto_fired
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_CAPT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int N_W = (W > 1) ? $clog2(W) : 1;

  logic [1:0]       state;
  logic [9:0]       in_data;
  logic             in_valid;
  logic [DIV_W-1:0] dcnt;
  logic [DIV_W-1:0] div_q;
  logic [9:0]       lvl_q;
  logic [9:0]       lo_q;
  logic [9:0]       hi_q;
  logic             slope_q;
  logic             pre;
  logic [N_W-1:0]   n;
  // Set once the W-th sample has gone out; holds Capture for the strobe
  // cycle so done lands on the cycle after the last strobe.
  logic             fin;

  // Saturating thresholds; the 11th bit catches under/overflow.
  logic [10:0] lo11;
  logic [10:0] hi11;
  logic [9:0]  lo_nxt;
  logic [9:0]  hi_nxt;

  assign lo11   = {1'b0, level} - 11'(HYST);
  assign hi11   = {1'b0, level} + 11'(HYST);
  assign lo_nxt = lo11[10] ? 10'd0    : lo11[9:0];
  assign hi_nxt = hi11[10] ? 10'h3FF  : hi11[9:0];

  logic kept;
  logic pre_hit;
  logic trig_hit;
  logic auto_hit;
  logic start;
  logic emit;
  logic last;

  assign kept     = in_valid && (dcnt == div_q);
  assign pre_hit  = slope_q ? (in_data >= hi_q) : (in_data <= lo_q);
  assign trig_hit = pre && (slope_q ? (in_data <= lvl_q) : (in_data >= lvl_q));
  assign start    = (state == S_WAIT) && kept && (trig_hit || auto_hit);
  assign emit     = start || ((state == S_CAPT) && !fin && kept);
  assign last     = emit && (n == N_W'(W - 1));

  assign capturing = (state == S_CAPT);
  assign done      = (state == S_DONE);

  always_ff @(posedge clkSmpl or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      in_data    <= '0;
      in_valid   <= 1'b0;
      dcnt       <= '0;
      div_q      <= '0;
      lvl_q      <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      slope_q    <= 1'b0;
      pre        <= 1'b0;
      n          <= '0;
      fin        <= 1'b0;
      smpl_data  <= '0;
      smpl_valid <= 1'b0;
    end else begin
      in_data    <= adc_data;
      in_valid   <= adc_valid;
      smpl_valid <= emit;
      if (emit) begin
        smpl_data <= in_data;
        n         <= last ? '0 : n + 1'b1;
      end

      if (state == S_IDLE) begin
        dcnt <= '0;
      end else if (in_valid) begin
        dcnt <= kept ? '0 : dcnt + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (arm) begin
            state   <= S_WAIT;
            div_q   <= div;
            lvl_q   <= level;
            lo_q    <= lo_nxt;
            hi_q    <= hi_nxt;
            slope_q <= slope;
            pre     <= 1'b0;
            n       <= '0;
            fin     <= 1'b0;
          end
        end
        S_WAIT: begin
          if (kept && pre_hit) pre <= 1'b1;
          if (last) fin <= 1'b1;
          if (start) state <= S_CAPT;
        end
        S_CAPT: begin
          if (last) fin <= 1'b1;
          if (fin) state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SMPL_TRIGGER_AUTO_EN
  localparam int T_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [T_W-1:0] tcnt;
  logic           tmax;

  assign tmax     = (tcnt == T_W'(TIMEOUT - 1));
  assign auto_hit = auto_mode && tmax;

  always_ff @(posedge clkSmpl or posedge reset) begin
    if (reset) begin
      tcnt       <= '0;
      auto_fired <= 1'b0;
    end else if ((state == S_IDLE) && arm) begin
      tcnt       <= '0;
      auto_fired <= 1'b0;
    end else if ((state == S_WAIT) && kept) begin
      // A real trigger on the timeout sample takes precedence.
      if (auto_hit && !trig_hit) auto_fired <= 1'b1;
      // Saturate so a long wait with auto_mode low cannot wrap.
      if (!tmax) tcnt <= tcnt + 1'b1;
    end
  end
`else
  logic unused_auto;

  assign auto_hit    = 1'b0;
  assign auto_fired  = 1'b0;
  assign unused_auto = auto_mode ^ (TIMEOUT == 0);
`endif

endmodule

// File: tb/tb_smpl_trigger.sv
module tb_smpl_trigger;

  localparam int W       = 4;
  localparam int HYST    = 8;
  localparam int TIMEOUT = 16;
  localparam int DIV_W   = 8;

  logic             clkSmpl = 1'b0;
  logic             reset   = 1'b1;
  logic [9:0]       adc_data  = '0;
  logic             adc_valid = 1'b0;
  logic             arm       = 1'b0;
  logic [9:0]       level     = 10'd512;
  logic             slope     = 1'b0;
  logic             auto_mode = 1'b0;
  logic [DIV_W-1:0] div       = '0;
  logic [9:0]       smpl_data;
  logic             smpl_valid;
  logic             capturing;
  logic             done;
  logic             auto_fired;

  smpl_trigger #(.W(W), .HYST(HYST), .TIMEOUT(TIMEOUT), .DIV_W(DIV_W)) dut (
    .clkSmpl   (clkSmpl),
    .reset     (reset),
    .adc_data  (adc_data),
    .adc_valid (adc_valid),
    .arm       (arm),
    .level     (level),
    .slope     (slope),
    .auto_mode (auto_mode),
    .div       (div),
    .smpl_data (smpl_data),
    .smpl_valid(smpl_valid),
    .capturing (capturing),
    .done      (done),
    .auto_fired(auto_fired)
  );

  always #5 clkSmpl = ~clkSmpl;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clkSmpl) cyc <= cyc + 1;

  // Strobe monitor, sampled on the falling edge.
  logic [9:0] q[$];
  int   first_cyc = -1;
  int   done_cnt  = 0;
  int   done_cyc  = -1;
  int   seq_bad   = 0;
  logic prev_valid = 1'b0;

  initial begin
    forever begin
      @(negedge clkSmpl);
      if (smpl_valid === 1'b1) begin
        if (q.size() == 0) first_cyc = cyc;
        q.push_back(smpl_data);
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        if (prev_valid !== 1'b1) seq_bad++;
      end
      if ((smpl_valid === 1'b1 && capturing !== 1'b1) || (done === 1'b1 && capturing !== 1'b0)) seq_bad++;
      prev_valid = smpl_valid;
    end
  end

  task automatic send(input logic [9:0] v);
    @(negedge clkSmpl);
    adc_data  = v;
    adc_valid = 1'b1;
  endtask

  task automatic gap(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clkSmpl);
      adc_valid = 1'b0;
    end
  endtask

  task automatic do_arm();
    @(negedge clkSmpl);
    adc_valid = 1'b0;
    arm = 1'b1;
    @(negedge clkSmpl);
    arm = 1'b0;
  endtask

  task automatic clr();
    q.delete();
    first_cyc = -1;
    done_cnt  = 0;
    done_cyc  = -1;
    seq_bad   = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clkSmpl);
    n_checks++; if (smpl_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", smpl_valid); end
    n_checks++; if (smpl_data !== 10'd0) begin n_fail++; $display("FAIL reset_data: got %0d want 0", smpl_data); end
    n_checks++; if (capturing !== 1'b0) begin n_fail++; $display("FAIL reset_capturing: got %b want 0", capturing); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (auto_fired !== 1'b0) begin n_fail++; $display("FAIL reset_auto_fired: got %b want 0", auto_fired); end
    reset = 1'b0;
    gap(2);
  endtask

  task automatic test_rising();
    logic [9:0] vals [7] = '{10'd400, 10'd450, 10'd500, 10'd550, 10'd600, 10'd650, 10'd700};
    logic [9:0] exp  [4] = '{10'd550, 10'd600, 10'd650, 10'd700};
    logic [9:0] got;
    int t = -1;
    level = 10'd512; slope = 1'b0; div = '0; auto_mode = 1'b0;
    clr();
    do_arm();
    level = 10'd300;  // must be ignored: thresholds latched at arming
    for (int i = 0; i < 7; i++) begin
      send(vals[i]);
      if (i == 3) t = cyc;
    end
    gap(8);
    level = 10'd512;
    n_checks++; if (q.size() !== 4) begin n_fail++; $display("FAIL rise_count: got %0d want 4", q.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < q.size()) ? q[i] : 'x;
      n_checks++; if (got !== exp[i]) begin n_fail++; $display("FAIL rise_sample%0d: got %0d want %0d", i, got, exp[i]); end
    end
    n_checks++; if (first_cyc !== t + 2) begin n_fail++; $display("FAIL rise_latency: got cycle %0d want %0d", first_cyc, t + 2); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL rise_done_count: got %0d want 1", done_cnt); end
    n_checks++; if (done_cyc !== first_cyc + 4) begin n_fail++; $display("FAIL rise_done_cycle: got %0d want %0d", done_cyc, first_cyc + 4); end
    n_checks++; if (seq_bad !== 0) begin n_fail++; $display("FAIL rise_sequence: got %0d bad cycles want 0", seq_bad); end
    n_checks++; if (auto_fired !== 1'b0) begin n_fail++; $display("FAIL rise_auto_fired: got %b want 0", auto_fired); end
  endtask

  task automatic test_hysteresis();
    logic [9:0] exp [4] = '{10'd520, 10'd530, 10'd540, 10'd550};
    logic [9:0] got;
    int t = -1;
    level = 10'd512; slope = 1'b0; div = '0;
    clr();
    do_arm();
    repeat (10) begin send(10'd510); send(10'd515); end
    gap(4);
    n_checks++; if (q.size() !== 0) begin n_fail++; $display("FAIL hyst_reject: got %0d strobes want 0", q.size()); end
    send(10'd500);
    send(10'd520); t = cyc;
    send(10'd530); send(10'd540); send(10'd550);
    gap(8);
    n_checks++; if (q.size() !== 4) begin n_fail++; $display("FAIL hyst_count: got %0d want 4", q.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < q.size()) ? q[i] : 'x;
      n_checks++; if (got !== exp[i]) begin n_fail++; $display("FAIL hyst_sample%0d: got %0d want %0d", i, got, exp[i]); end
    end
    n_checks++; if (first_cyc !== t + 2) begin n_fail++; $display("FAIL hyst_start: got cycle %0d want %0d", first_cyc, t + 2); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL hyst_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_falling();
    logic [9:0] exp [4] = '{10'd1000, 10'd990, 10'd980, 10'd970};
    logic [9:0] got;
    int t = -1;
    level = 10'd1020; slope = 1'b1; div = '0;
    clr();
    do_arm();
    send(10'd1010); send(10'd1000); send(10'd1023);
    send(10'd1000); t = cyc;
    send(10'd990); send(10'd980); send(10'd970);
    gap(8);
    slope = 1'b0; level = 10'd512;
    n_checks++; if (q.size() !== 4) begin n_fail++; $display("FAIL fall_count: got %0d want 4", q.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < q.size()) ? q[i] : 'x;
      n_checks++; if (got !== exp[i]) begin n_fail++; $display("FAIL fall_sample%0d: got %0d want %0d", i, got, exp[i]); end
    end
    n_checks++; if (first_cyc !== t + 2) begin n_fail++; $display("FAIL fall_start: got cycle %0d want %0d", first_cyc, t + 2); end
  endtask

  task automatic test_decimation();
    logic [9:0] vals [18] = '{10'd700, 10'd700, 10'd100, 10'd100, 10'd100, 10'd600,
                              10'd601, 10'd602, 10'd610, 10'd611, 10'd612, 10'd620,
                              10'd621, 10'd622, 10'd630, 10'd631, 10'd632, 10'd640};
    logic [9:0] exp [4] = '{10'd600, 10'd610, 10'd620, 10'd630};
    logic [9:0] got;
    level = 10'd512; slope = 1'b0; div = 8'd2;
    clr();
    do_arm();
    div = 8'd0;  // must be ignored: divider latched at arming
    for (int i = 0; i < 18; i++) begin
      if (i == 11) gap(3);
      send(vals[i]);
    end
    gap(8);
    n_checks++; if (q.size() !== 4) begin n_fail++; $display("FAIL dec_count: got %0d want 4", q.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < q.size()) ? q[i] : 'x;
      n_checks++; if (got !== exp[i]) begin n_fail++; $display("FAIL dec_sample%0d: got %0d want %0d", i, got, exp[i]); end
    end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL dec_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_auto();
    logic [9:0] got;
    int t = -1;
    level = 10'd512; slope = 1'b0; div = '0; auto_mode = 1'b1;
`ifdef SMPL_TRIGGER_AUTO_EN
    clr();
    do_arm();
    for (int i = 1; i <= 20; i++) begin
      send(10'd300);
      if (i == 16) t = cyc;
    end
    gap(8);
    n_checks++; if (q.size() !== 4) begin n_fail++; $display("FAIL auto_count: got %0d want 4", q.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < q.size()) ? q[i] : 'x;
      n_checks++; if (got !== 10'd300) begin n_fail++; $display("FAIL auto_sample%0d: got %0d want 300", i, got); end
    end
    n_checks++; if (first_cyc !== t + 2) begin n_fail++; $display("FAIL auto_start: got cycle %0d want %0d", first_cyc, t + 2); end
    n_checks++; if (auto_fired !== 1'b1) begin n_fail++; $display("FAIL auto_fired_set: got %b want 1", auto_fired); end
    // Real trigger on the timeout sample wins.
    clr();
    do_arm();
    gap(1);
    n_checks++; if (auto_fired !== 1'b0) begin n_fail++; $display("FAIL auto_fired_clear: got %b want 0", auto_fired); end
    repeat (15) send(10'd300);
    send(10'd600); send(10'd610); send(10'd620); send(10'd630);
    gap(8);
    got = (q.size() > 0) ? q[0] : 'x;
    n_checks++; if (got !== 10'd600) begin n_fail++; $display("FAIL auto_tie_sample0: got %0d want 600", got); end
    n_checks++; if (auto_fired !== 1'b0) begin n_fail++; $display("FAIL auto_tie_fired: got %b want 0", auto_fired); end
`else
    clr();
    do_arm();
    repeat (20) send(10'd300);
    gap(4);
    n_checks++; if (q.size() !== 0) begin n_fail++; $display("FAIL noauto_idle: got %0d strobes want 0", q.size()); end
    n_checks++; if (auto_fired !== 1'b0) begin n_fail++; $display("FAIL noauto_fired: got %b want 0", auto_fired); end
    send(10'd520); t = cyc;
    send(10'd530); send(10'd540); send(10'd550);
    gap(8);
    got = (q.size() > 0) ? q[0] : 'x;
    n_checks++; if (got !== 10'd520) begin n_fail++; $display("FAIL noauto_sample0: got %0d want 520", got); end
    n_checks++; if (first_cyc !== t + 2) begin n_fail++; $display("FAIL noauto_start: got cycle %0d want %0d", first_cyc, t + 2); end
`endif
    auto_mode = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [9:0] exp [4] = '{10'd600, 10'd610, 10'd620, 10'd630};
    logic [9:0] got;
    level = 10'd512; slope = 1'b0; div = '0;
    clr();
    do_arm();
    send(10'd400); send(10'd550); send(10'd560); send(10'd570); send(10'd580);
    #1;
    n_checks++; if (q.size() !== 2) begin n_fail++; $display("FAIL mid_pre_reset: got %0d strobes want 2", q.size()); end
    reset = 1'b1;
    @(negedge clkSmpl);
    adc_valid = 1'b0;
    n_checks++; if (smpl_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b want 0", smpl_valid); end
    n_checks++; if (smpl_data !== 10'd0) begin n_fail++; $display("FAIL mid_data: got %0d want 0", smpl_data); end
    n_checks++; if (capturing !== 1'b0) begin n_fail++; $display("FAIL mid_capturing: got %b want 0", capturing); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mid_done: got %b want 0", done); end
    @(negedge clkSmpl);
    reset = 1'b0;
    gap(10);
    n_checks++; if (q.size() !== 2) begin n_fail++; $display("FAIL mid_after_reset: got %0d strobes want 2", q.size()); end
    n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL mid_no_done: got %0d want 0", done_cnt); end
    clr();
    do_arm();
    send(10'd400); send(10'd600); send(10'd610); send(10'd620); send(10'd630);
    gap(8);
    n_checks++; if (q.size() !== 4) begin n_fail++; $display("FAIL rearm_count: got %0d want 4", q.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < q.size()) ? q[i] : 'x;
      n_checks++; if (got !== exp[i]) begin n_fail++; $display("FAIL rearm_sample%0d: got %0d want %0d", i, got, exp[i]); end
    end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL rearm_done_count: got %0d want 1", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_rising();
    test_hysteresis();
    test_falling();
    test_decimation();
    test_auto();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
